// File: rtl/pulse_synth_pkg.sv
// Shared types and default widths for the pulse synthesizer.
package pulse_synth_pkg;

  localparam int AXIS_TDATA_WIDTH_DEF = 32;
  localparam int DAC_WIDTH_DEF        = 14;
  localparam int COUNT_WIDTH_DEF      = 32;
  localparam logic [15:0] LFSR_SEED   = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/pulse_synth_lfsr.sv
// 16-bit Fibonacci LFSR noise source; only compiled when PULSE_SYNTH_NOISE_EN is defined.
`ifdef PULSE_SYNTH_NOISE_EN
module pulse_synth_lfsr
  import pulse_synth_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  output logic signed [3:0] noise
);

  logic [15:0] lfsr;

  // Taps 16,14,13,11 give a maximal-length sequence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      lfsr <= LFSR_SEED;
    else if (step)
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign noise = lfsr[3:0];

endmodule
`endif

// File: rtl/pulse_synthesizer.sv
// Burst generator streaming amplitude/baseline beats over AXI-Stream.
// Optional dither noise on samples is enabled by defining PULSE_SYNTH_NOISE_EN.
module pulse_synthesizer
  import pulse_synth_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = AXIS_TDATA_WIDTH_DEF,
  parameter int DAC_WIDTH        = DAC_WIDTH_DEF,
  parameter int COUNT_WIDTH      = COUNT_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic signed [DAC_WIDTH-1:0] amplitude,
  input  logic signed [DAC_WIDTH-1:0] baseline,
  input  logic [COUNT_WIDTH-1:0]      high_cycles,
  input  logic [COUNT_WIDTH-1:0]      low_cycles,
  input  logic [COUNT_WIDTH-1:0]      n_pulses,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_OUT_tdata,
  output logic                        M_AXIS_OUT_tvalid,
  input  logic                        M_AXIS_OUT_tready,
  output logic                        busy,
  output logic                        done,
  output logic [COUNT_WIDTH-1:0]      pulses_sent
);

  localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

  state_t                   state;
  logic signed [DAC_WIDTH-1:0] amp_q, base_q;
  logic [COUNT_WIDTH-1:0]   high_q, low_q, n_q, beat_cnt;
  logic                     active, accept;
  logic signed [DAC_WIDTH-1:0] nominal, sample;

  assign active = (state == ST_HIGH) || (state == ST_LOW);
  assign accept = active && M_AXIS_OUT_tready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      amp_q       <= '0;
      base_q      <= '0;
      high_q      <= '0;
      low_q       <= '0;
      n_q         <= '0;
      beat_cnt    <= '0;
      pulses_sent <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // abort wins over a simultaneous start
          if (start && !abort) begin
            amp_q       <= amplitude;
            base_q      <= baseline;
            high_q      <= (high_cycles == '0) ? ONE : high_cycles;
            low_q       <= (low_cycles == '0) ? ONE : low_cycles;
            n_q         <= n_pulses;
            beat_cnt    <= '0;
            pulses_sent <= '0;
            state       <= (n_pulses == '0) ? ST_DONE : ST_HIGH;
          end
        end
        ST_HIGH: begin
          if (abort) begin
            beat_cnt <= '0;
            state    <= ST_IDLE;
          end else if (accept) begin
            if (beat_cnt == high_q - ONE) begin
              beat_cnt    <= '0;
              pulses_sent <= pulses_sent + ONE;
              state       <= ST_LOW;
            end else begin
              beat_cnt <= beat_cnt + ONE;
            end
          end
        end
        ST_LOW: begin
          if (abort) begin
            beat_cnt <= '0;
            state    <= ST_IDLE;
          end else if (accept) begin
            if (beat_cnt == low_q - ONE) begin
              beat_cnt <= '0;
              state    <= (pulses_sent == n_q) ? ST_DONE : ST_HIGH;
            end else begin
              beat_cnt <= beat_cnt + ONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign nominal = (state == ST_HIGH) ? amp_q : base_q;

`ifdef PULSE_SYNTH_NOISE_EN
  logic signed [3:0]         noise;
  logic signed [DAC_WIDTH:0] sum;

  // LFSR only steps on accepted beats, so the sample holds through stalls.
  pulse_synth_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .step  (accept),
    .noise (noise)
  );

  assign sum = (DAC_WIDTH+1)'(nominal) + (DAC_WIDTH+1)'(noise);

  always_comb begin
    sample = sum[DAC_WIDTH-1:0];
    if (sum[DAC_WIDTH] != sum[DAC_WIDTH-1])
      sample = sum[DAC_WIDTH] ? {1'b1, {(DAC_WIDTH-1){1'b0}}}
                              : {1'b0, {(DAC_WIDTH-1){1'b1}}};
  end
`else
  assign sample = nominal;
`endif

  assign M_AXIS_OUT_tvalid = active;
  assign M_AXIS_OUT_tdata  = active ? AXIS_TDATA_WIDTH'(sample) : '0;
  assign busy              = active;
  assign done              = (state == ST_DONE);

endmodule

// File: tb/tb_pulse_synthesizer.sv
// Scoreboard bench for pulse_synthesizer; expected beats queued at start, checked on handshake.
module tb_pulse_synthesizer;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic signed [13:0] amplitude = '0;
  logic signed [13:0] baseline = '0;
  logic [31:0]        high_cycles = '0;
  logic [31:0]        low_cycles = '0;
  logic [31:0]        n_pulses = '0;
  logic [31:0]        M_AXIS_OUT_tdata;
  logic               M_AXIS_OUT_tvalid;
  logic               M_AXIS_OUT_tready = 1'b1;
  logic               busy;
  logic               done;
  logic [31:0]        pulses_sent;

  int errors = 0;
  int checks = 0;
  int beats  = 0;
  int exp_q[$];
  bit mon_en = 1'b1;
  bit stall_pending = 1'b0;
  logic [31:0] last_data = '0;

  pulse_synthesizer dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .amplitude         (amplitude),
    .baseline          (baseline),
    .high_cycles       (high_cycles),
    .low_cycles        (low_cycles),
    .n_pulses          (n_pulses),
    .M_AXIS_OUT_tdata  (M_AXIS_OUT_tdata),
    .M_AXIS_OUT_tvalid (M_AXIS_OUT_tvalid),
    .M_AXIS_OUT_tready (M_AXIS_OUT_tready),
    .busy              (busy),
    .done              (done),
    .pulses_sent       (pulses_sent)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: every accepted beat is matched against the queue head.
  always @(negedge clk) begin
    if (rst && mon_en) begin
      if (M_AXIS_OUT_tvalid && stall_pending) begin
        checks++;
        if (M_AXIS_OUT_tdata !== last_data) begin
          errors++;
          $display("FAIL stall_stable: tdata=%h required %h", M_AXIS_OUT_tdata, last_data);
        end
      end
      if (M_AXIS_OUT_tvalid && M_AXIS_OUT_tready) begin
        checks++;
        beats++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: tdata=%h with empty scoreboard", M_AXIS_OUT_tdata);
        end else begin
          automatic int e = exp_q.pop_front();
`ifdef PULSE_SYNTH_NOISE_EN
          automatic logic signed [13:0] s = M_AXIS_OUT_tdata[13:0];
          automatic int d = s;
          automatic logic [17:0] ext = M_AXIS_OUT_tdata[31:14];
          if (d - e > 8 || e - d > 8 || ext !== {18{s[13]}}) begin
            errors++;
            $display("FAIL beat_noise: tdata=%h required within 8 of %0d", M_AXIS_OUT_tdata, e);
          end
`else
          if (M_AXIS_OUT_tdata !== 32'(e)) begin
            errors++;
            $display("FAIL beat_data: tdata=%h required %h", M_AXIS_OUT_tdata, 32'(e));
          end
`endif
        end
      end
      stall_pending = M_AXIS_OUT_tvalid && !M_AXIS_OUT_tready;
      last_data     = M_AXIS_OUT_tdata;
    end else begin
      stall_pending = 1'b0;
    end
  end

  task automatic test_reset();
    #2;
    checks += 5;
    if (M_AXIS_OUT_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b required 0", M_AXIS_OUT_tvalid); end
    if (M_AXIS_OUT_tdata !== 32'd0) begin errors++; $display("FAIL reset_tdata: got %h required 0", M_AXIS_OUT_tdata); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", done); end
    if (pulses_sent !== 32'd0) begin errors++; $display("FAIL reset_pulses: got %0d required 0", pulses_sent); end
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: busy=%b required 0", busy); end
  endtask

  task automatic run_burst(input int amp, input int base, input int hi, input int lo,
                           input int n, input bit toggle, input string name);
    int h, l, dcnt;
    h = (hi == 0) ? 1 : hi;
    l = (lo == 0) ? 1 : lo;
    for (int p = 0; p < n; p++) begin
      for (int i = 0; i < h; i++) exp_q.push_back(amp);
      for (int i = 0; i < l; i++) exp_q.push_back(base);
    end
    beats = 0;
    @(posedge clk);
    #1;
    amplitude = 14'(amp); baseline = 14'(base);
    high_cycles = hi; low_cycles = lo; n_pulses = n;
    start = 1'b1; M_AXIS_OUT_tready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    // Scramble config mid-burst; the latched copy must be used.
    amplitude = 14'($urandom); baseline = 14'($urandom);
    high_cycles = $urandom_range(1, 9); low_cycles = $urandom_range(1, 9);
    n_pulses = $urandom_range(0, 9);
    @(negedge clk);
    checks += 2;
    if (M_AXIS_OUT_tvalid !== (n != 0)) begin errors++; $display("FAIL %s_latency: tvalid=%b required %b", name, M_AXIS_OUT_tvalid, n != 0); end
    if (done !== (n == 0)) begin errors++; $display("FAIL %s_done_timing: done=%b required %b", name, done, n == 0); end
    dcnt = done ? 1 : 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if (toggle) M_AXIS_OUT_tready = ~M_AXIS_OUT_tready;
      start = busy && (c == 3);
      @(negedge clk);
      if (done) dcnt++;
      else if (dcnt != 0) break;
    end
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    M_AXIS_OUT_tready = 1'b1;
    checks += 5;
    if (dcnt != 1) begin errors++; $display("FAIL %s_done_once: done pulses=%0d required 1", name, dcnt); end
    if (pulses_sent !== 32'(n)) begin errors++; $display("FAIL %s_pulses: got %0d required %0d", name, pulses_sent, n); end
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_end: got %b required 0", name, busy); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL %s_missing: %0d beats not seen required 0", name, exp_q.size()); end
    if (beats != n * (h + l)) begin errors++; $display("FAIL %s_beats: got %0d required %0d", name, beats, n * (h + l)); end
    exp_q.delete();
  endtask

  task automatic test_abort();
    int dcnt;
    bit found;
    // 3 HIGH + 2 LOW, then the first beat of pulse 2 is presented as abort lands.
    repeat (3) exp_q.push_back(1234);
    repeat (2) exp_q.push_back(-77);
    exp_q.push_back(1234);
    @(posedge clk);
    #1;
    amplitude = 14'(1234); baseline = -14'sd77;
    high_cycles = 3; low_cycles = 2; n_pulses = 5; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      if (pulses_sent == 32'd1 && M_AXIS_OUT_tvalid && M_AXIS_OUT_tdata == 32'd1234) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL abort_reach_high2: second HIGH not reached within bound"); end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    checks += 4;
    if (M_AXIS_OUT_tvalid !== 1'b0) begin errors++; $display("FAIL abort_tvalid: got %b required 0", M_AXIS_OUT_tvalid); end
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy); end
    if (pulses_sent !== 32'd1) begin errors++; $display("FAIL abort_pulses: got %0d required 1", pulses_sent); end
    if (exp_q.size() != 0) begin errors++; $display("FAIL abort_missing: %0d beats not seen required 0", exp_q.size()); end
    dcnt = done ? 1 : 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    checks++;
    if (dcnt != 0) begin errors++; $display("FAIL abort_no_done: done pulses=%0d required 0", dcnt); end
    // abort and start together in IDLE: abort wins
    @(posedge clk);
    #1 start = 1'b1; abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks += 2;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_vs_start: busy=%b required 0", busy); end
    if (pulses_sent !== 32'd1) begin errors++; $display("FAIL abort_vs_start_pulses: got %0d required 1", pulses_sent); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    amplitude = 14'(500); baseline = 14'(20);
    high_cycles = 2; low_cycles = 2; n_pulses = 4; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    checks += 5;
    if (M_AXIS_OUT_tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b required 0", M_AXIS_OUT_tvalid); end
    if (M_AXIS_OUT_tdata !== 32'd0) begin errors++; $display("FAIL rstmid_tdata: got %h required 0", M_AXIS_OUT_tdata); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b required 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b required 0", done); end
    if (pulses_sent !== 32'd0) begin errors++; $display("FAIL rstmid_pulses: got %0d required 0", pulses_sent); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;
    run_burst(-900, 300, 2, 1, 2, 1'b0, "after_reset");
  endtask

  initial begin
    test_reset();
    run_burst(6000, 0, 3, 2, 2, 1'b0, "basic");
    run_burst(6000, 0, 3, 2, 2, 1'b1, "stall");
    run_burst(1000, -5, 3, 2, 0, 1'b0, "n_zero");
    run_burst(-3000, 250, 0, 0, 3, 1'b0, "zero_len");
    run_burst(-8192, 8191, 1, 2, 2, 1'b1, "extremes");
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
